// File: rtl/lfsr_16bit_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : lfsr_16bit_checker                                               |
// | Purpose : Self-synchronising receive checker for the 16-bit LFSR stream;   |
// |           locks after a run of correct predictions, then counts errors.    |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module lfsr_16bit_checker #(
  parameter int LOCK_CNT  = 4,
  parameter int LOSS_CNT  = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic [15:0]          data_i,
  input  logic                 clear_i,
  output logic                 locked_o,
  output logic                 err_o,
  output logic [CNT_WIDTH-1:0] err_cnt_o
);

  localparam int c_match_w = $clog2(LOCK_CNT + 1);
  localparam int c_miss_w  = $clog2(LOSS_CNT + 1);
  localparam logic [c_match_w-1:0] c_match_one = c_match_w'(1);
  localparam logic [c_miss_w-1:0]  c_miss_one  = c_miss_w'(1);
  localparam logic [CNT_WIDTH-1:0] c_cnt_one   = CNT_WIDTH'(1);
  localparam logic [c_match_w-1:0] c_lock_at   = c_match_w'(LOCK_CNT);
  localparam logic [c_miss_w-1:0]  c_loss_at   = c_miss_w'(LOSS_CNT);

  typedef enum logic [0:0] {
    S_HUNT   = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  function automatic logic [15:0] f_nxt(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  state_t                 r_state;
  logic [15:0]            r_exp;
  logic                   r_seeded;
  logic [c_match_w-1:0]   r_match;
  logic [c_miss_w-1:0]    r_miss;
  logic                   r_err;
  logic [CNT_WIDTH-1:0]   r_err_cnt;

  logic                   w_hit;
  logic                   w_zero;
  logic [c_match_w-1:0]   w_match_inc;
  logic [c_miss_w-1:0]    w_miss_inc;
  logic                   w_cnt_inc;
  logic                   w_cnt_sat;

  assign w_hit       = (data_i == r_exp);
  assign w_zero      = (data_i == 16'h0000);
  assign w_match_inc = r_match + c_match_one;
  assign w_miss_inc  = r_miss + c_miss_one;
  assign w_cnt_inc   = en_i && (r_state == S_LOCKED) && !w_hit;
  assign w_cnt_sat   = &r_err_cnt;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state   <= S_HUNT;
      r_exp     <= 16'h0000;
      r_seeded  <= 1'b0;
      r_match   <= '0;
      r_miss    <= '0;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_err <= 1'b0;
      if (en_i) begin
        case (r_state)
          S_HUNT: begin
            // Zero is outside the LFSR orbit, so it can never seed a prediction.
            if (w_zero) begin
              r_seeded <= 1'b0;
              r_match  <= '0;
            end else begin
              r_exp    <= f_nxt(data_i);
              r_seeded <= 1'b1;
              if (r_seeded && w_hit) begin
                r_match <= w_match_inc;
                if (w_match_inc == c_lock_at) begin
                  r_state <= S_LOCKED;
                  r_miss  <= '0;
                end
              end else begin
                r_match <= '0;
              end
            end
          end
          S_LOCKED: begin
            // Flywheel: the prediction advances on its own, never reseeded.
            r_exp <= f_nxt(r_exp);
            if (w_hit) begin
              r_miss <= '0;
            end else begin
              r_err  <= 1'b1;
              r_miss <= w_miss_inc;
              if (w_miss_inc == c_loss_at) begin
                r_state  <= S_HUNT;
                r_match  <= '0;
                r_seeded <= 1'b0;
              end
            end
          end
          default: r_state <= S_HUNT;
        endcase
      end
      if (clear_i) begin
        r_err_cnt <= '0;
      end else if (w_cnt_inc && !w_cnt_sat) begin
        r_err_cnt <= r_err_cnt + c_cnt_one;
      end
    end
  end

  assign locked_o  = (r_state == S_LOCKED);
  assign err_o     = r_err;
  assign err_cnt_o = r_err_cnt;

endmodule
`default_nettype wire
